// File: rtl/vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// vga_scan_ctrl
//
// Raster scan generator for a VGA-style display. A clock divider makes a
// one-clk pixel strobe every CLK_DIV system clocks. On each strobe the
// column/line counters advance, and the sync and colour outputs are registered
// from the pre-increment counter position. Sync and colour therefore always
// describe the same pixel, and they appear one clk after that pixel's strobe.
//
// Ports
//   clk          system clock; all logic runs on its rising edge
//   rst          synchronous, active-high reset
//   pixel_in     composed colour {R,G,B}, 4 bits each, sampled on pixel_tick
//   pixel_tick   one-clk pixel strobe (combinational from the divider)
//   h_cnt        current column, 0..H_TOTAL-1
//   v_cnt        current line,   0..V_TOTAL-1
//   vga_valid    (h_cnt,v_cnt) lies in the visible area (combinational)
//   frame_start  one-clk pulse on the tick that wraps the whole frame
//   hsync/vsync  active-low syncs, registered
//   vgaRed/vgaGreen/vgaBlue  registered colour to the DAC, blanked off-screen
// -----------------------------------------------------------------------------
module vga_scan_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int H_DISP  = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_DISP  = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] pixel_in,
   output logic        pixel_tick,
   output logic [9:0]  h_cnt,
   output logic [9:0]  v_cnt,
   output logic        vga_valid,
   output logic        frame_start,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  vgaRed,
   output logic [3:0]  vgaGreen,
   output logic [3:0]  vgaBlue
);

   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

   // A divide-by-1 still needs a one-bit counter so the compare is legal.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Counter boundaries sized to the 10-bit counters.
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISP);
   localparam logic [9:0] V_VIS    = 10'(V_DISP);
   localparam logic [9:0] HS_BEG   = 10'(H_DISP + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_DISP + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);

   // State
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]       h_cnt_q,   h_cnt_d;
   logic [9:0]       v_cnt_q,   v_cnt_d;
   logic             hsync_q,   hsync_d;
   logic             vsync_q,   vsync_d;
   logic [11:0]      rgb_q,     rgb_d;

   // Decodes of the current (pre-increment) position
   logic h_wrap;
   logic v_wrap;
   logic in_hsync;
   logic in_vsync;

   always_comb begin
      // Divider: one strobe per CLK_DIV clks, on the last count.
      pixel_tick = (div_cnt_q == DIV_LAST);
      div_cnt_d  = pixel_tick ? '0 : div_cnt_q + DIV_W'(1);

      h_wrap   = (h_cnt_q == H_LAST);
      v_wrap   = (v_cnt_q == V_LAST);
      in_hsync = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      in_vsync = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

      vga_valid   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      frame_start = pixel_tick && h_wrap && v_wrap;

      // Defaults: everything holds between strobes.
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      rgb_d   = rgb_q;

      if (pixel_tick) begin
         // Line advances on the same strobe that wraps the column.
         if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end

         // Outputs come from the position before the increment so that sync
         // and colour describe the same pixel. Blanking outside the visible
         // area also guarantees black whenever a sync pulse is active.
         hsync_d = ~in_hsync;
         vsync_d = ~in_vsync;
         rgb_d   = vga_valid ? pixel_in : 12'h000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         rgb_q     <= 12'h000;
      end else begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         rgb_q     <= rgb_d;
      end
   end

   assign h_cnt    = h_cnt_q;
   assign v_cnt    = v_cnt_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign vgaRed   = rgb_q[11:8];
   assign vgaGreen = rgb_q[7:4];
   assign vgaBlue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_ctrl
//
// Two instances share clock, reset and pixel input: one with the standard
// 640x480 timing (single-line behaviour) and one with a shrunken raster so
// whole frames fit in a short run. An arithmetic model derives the expected
// outputs from the number of clks since the last reset edge.
// -----------------------------------------------------------------------------
module tb_vga_scan_ctrl;
   localparam int D = 4;

   // small raster: 25 x 13 pixels, 1300 clks per frame
   localparam int SHD = 16, SHF = 2, SHS = 4, SHB = 3;
   localparam int SVD = 8,  SVF = 1, SVS = 2, SVB = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [11:0] pixel_in = 12'h000;

   logic       d_tick, d_valid, d_fs, d_hs, d_vs;
   logic [9:0] d_h, d_v;
   logic [3:0] d_r, d_g, d_b;
   logic       s_tick, s_valid, s_fs, s_hs, s_vs;
   logic [9:0] s_h, s_v;
   logic [3:0] s_r, s_g, s_b;

   always #5 clk = ~clk;

   vga_scan_ctrl dut_d (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_tick(d_tick),
      .h_cnt(d_h), .v_cnt(d_v), .vga_valid(d_valid), .frame_start(d_fs),
      .hsync(d_hs), .vsync(d_vs), .vgaRed(d_r), .vgaGreen(d_g), .vgaBlue(d_b));

   vga_scan_ctrl #(.CLK_DIV(D), .H_DISP(SHD), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_DISP(SVD), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) dut_s (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_tick(s_tick),
      .h_cnt(s_h), .v_cnt(s_v), .vga_valid(s_valid), .frame_start(s_fs),
      .hsync(s_hs), .vsync(s_vs), .vgaRed(s_r), .vgaGreen(s_g), .vgaBlue(s_b));

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // k = clks elapsed since the last reset edge; lastpix = pixel_in captured
   // at the most recent pixel strobe.
   int          k = 0;
   bit          seen = 1'b0;
   logic [11:0] lastpix = 12'h000;

   always @(posedge clk) begin
      if (rst) begin
         k = 0;
         seen = 1'b1;
      end else begin
         if (k % D == D - 1) lastpix = pixel_in;
         k = k + 1;
      end
   end

   // {tick, h, v, valid, frame_start, hsync, vsync, rgb}
   function automatic logic [36:0] model(input int kk, input int hd, input int hf,
                                         input int hs_w, input int hb, input int vd,
                                         input int vf, input int vs_w, input int vb,
                                         input logic [11:0] lp);
      int ht = hd + hf + hs_w + hb;
      int vt = vd + vf + vs_w + vb;
      int ft = ht * vt;
      int t  = kk / D;
      int p  = t % ft;
      int h  = p % ht;
      int v  = p / ht;
      int pp, hp, vp;
      logic tick, valid, fs, hs, vs;
      logic [11:0] rgb;
      tick  = (kk % D) == D - 1;
      valid = (h < hd) && (v < vd);
      fs    = tick && (p == ft - 1);
      if (t == 0) begin
         hs = 1'b1; vs = 1'b1; rgb = 12'h000;
      end else begin
         pp  = (t - 1) % ft;
         hp  = pp % ht;
         vp  = pp / ht;
         hs  = !((hp >= hd + hf) && (hp < hd + hf + hs_w));
         vs  = !((vp >= vd + vf) && (vp < vd + vf + vs_w));
         rgb = ((hp < hd) && (vp < vd)) ? lp : 12'h000;
      end
      return {tick, 10'(h), 10'(v), valid, fs, hs, vs, rgb};
   endfunction

   always @(negedge clk) begin
      if (seen) begin
         chk("model_std",
             {27'd0, d_tick, d_h, d_v, d_valid, d_fs, d_hs, d_vs, d_r, d_g, d_b},
             {27'd0, model(k, 640, 16, 96, 48, 480, 10, 2, 33, lastpix)});
         chk("model_small",
             {27'd0, s_tick, s_h, s_v, s_valid, s_fs, s_hs, s_vs, s_r, s_g, s_b},
             {27'd0, model(k, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, lastpix)});
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        rst;
      logic [11:0] pix;
      logic        tick;
      logic [9:0]  h;
      logic [9:0]  v;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } vec_t;

   vec_t tbl[10];

   int fs_n, fs_first, fs_second, hs_low, hs_first, vs_low, tick_first;
   bit found;

   initial begin
      // reset cycle, then pixel strobes at k=3,7; pixel_in wiggles between them
      tbl[0] = '{1'b1, 12'h000, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 12'h000};
      tbl[1] = '{1'b0, 12'hF80, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 12'h000};
      tbl[2] = '{1'b0, 12'hF80, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 12'h000};
      tbl[3] = '{1'b0, 12'hF80, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 12'h000};
      tbl[4] = '{1'b0, 12'hF80, 1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 12'hF80};
      tbl[5] = '{1'b0, 12'h123, 1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 12'hF80};
      tbl[6] = '{1'b0, 12'h456, 1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 12'hF80};
      tbl[7] = '{1'b0, 12'h789, 1'b1, 10'd1, 10'd0, 1'b1, 1'b1, 12'hF80};
      tbl[8] = '{1'b0, 12'hABC, 1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 12'hABC};
      tbl[9] = '{1'b0, 12'h000, 1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 12'hABC};

      rst = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         rst      = tbl[i].rst;
         pixel_in = tbl[i].pix;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("tbl%0d_tick", i), d_tick, tbl[i].tick);
         chk($sformatf("tbl%0d_h", i), d_h, tbl[i].h);
         chk($sformatf("tbl%0d_v", i), d_v, tbl[i].v);
         chk($sformatf("tbl%0d_sync", i), {d_hs, d_vs}, {tbl[i].hs, tbl[i].vs});
         chk($sformatf("tbl%0d_rgb", i), {d_r, d_g, d_b}, tbl[i].rgb);
      end

      // free run with random colour: two small frames, one standard line
      fs_n = 0; fs_first = -1; fs_second = -1;
      hs_low = 0; hs_first = -1; vs_low = 0;
      while (k < 3400) begin
         if (s_fs) begin
            fs_n++;
            if (fs_first < 0) fs_first = k;
            else if (fs_second < 0) fs_second = k;
         end
         if (!d_hs) begin
            hs_low++;
            if (hs_first < 0) hs_first = k;
         end
         if (!s_vs) vs_low++;
         if (k == 3200) chk("line_wrap", {d_h, d_v}, {10'd0, 10'd1});
         pixel_in = 12'($urandom);
         @(negedge clk);
      end
      chk("fs_count", fs_n, 2);
      chk("fs_first", fs_first, 1299);
      chk("fs_period", fs_second - fs_first, 1300);
      chk("hs_low_clks", hs_low, 384);
      chk("hs_first_low", hs_first, 2628);
      chk("vs_low_clks", vs_low, 400);

      // reset in the middle of a small frame
      found = 1'b0;
      for (int n = 0; n < 2000 && !found; n++) begin
         if (s_h == 10'd12 && s_v == 10'd5) found = 1'b1;
         else begin
            pixel_in = 12'($urandom);
            @(negedge clk);
         end
      end
      chk("mid_pos_found", found, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_small", {s_tick, s_fs, s_h, s_v, s_hs, s_vs, s_r, s_g, s_b},
          {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 12'h000});
      chk("mid_rst_std", {d_tick, d_fs, d_h, d_v, d_hs, d_vs, d_r, d_g, d_b},
          {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 12'h000});
      rst = 1'b0;

      tick_first = -1;
      for (int n = 0; n < 1400; n++) begin
         pixel_in = 12'($urandom);
         @(negedge clk);
         if (s_tick && tick_first < 0) tick_first = k;
      end
      chk("first_tick_after_rst", tick_first, 3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
